// File: rtl/key_fetch_client.sv
// key_fetch_client: requester side of the keymem key lookup, one timed-out keymem transaction per lookup.
// Optional single-entry key cache is built when KEY_FETCH_CLIENT_CACHE_EN is defined.
module key_fetch_client #(
  parameter int unsigned TIMEOUT_CYCLES    = 256,
  parameter int unsigned KEY_WIDTH         = 256,
  parameter int unsigned ID_WIDTH          = 32,
  parameter int unsigned TIMEOUT_CNT_WIDTH = 16   // saturation width of timeout_cnt, 1..16
) (
  input  logic                 clk156,
  input  logic                 areset_clk156,
  input  logic                 lookup_valid,
  output logic                 lookup_ready,
  input  logic [ID_WIDTH-1:0]  lookup_id,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic                 result_ok,
  output logic [KEY_WIDTH-1:0] result_key,
  output logic                 key_req,
  output logic [ID_WIDTH-1:0]  key_id,
  input  logic                 key_ack,
  input  logic [KEY_WIDTH-1:0] key,
  input  logic                 cache_flush,
  output logic [15:0]          timeout_cnt
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_CNT_WIDTH-1:0] TCNT_MAX = {TIMEOUT_CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [WAIT_W-1:0]            wait_q, wait_d;
  logic [ID_WIDTH-1:0]          key_id_q, key_id_d;
  logic                         result_ok_q, result_ok_d;
  logic [KEY_WIDTH-1:0]         result_key_q, result_key_d;
  logic [TIMEOUT_CNT_WIDTH-1:0] timeout_cnt_q, timeout_cnt_d;
  logic                         key_req_q, key_req_d;
  logic                         lookup_ready_q, lookup_ready_d;
  logic                         result_valid_q, result_valid_d;
  logic                         timeout_s;
  logic                         cache_hit_s;
  logic [KEY_WIDTH-1:0]         cache_key_s;

`ifdef KEY_FETCH_CLIENT_CACHE_EN
  logic                 cache_valid_q, cache_valid_d;
  logic [ID_WIDTH-1:0]  cache_id_q, cache_id_d;
  logic [KEY_WIDTH-1:0] cache_key_q, cache_key_d;

  // A flush in the accept cycle forces a miss.
  assign cache_hit_s = cache_valid_q && (cache_id_q == lookup_id) && !cache_flush;
  assign cache_key_s = cache_key_q;

  // Cache update: flush has priority over storing a fresh key.
  always_comb begin
    cache_valid_d = cache_valid_q;
    cache_id_d    = cache_id_q;
    cache_key_d   = cache_key_q;
    if (cache_flush) begin
      cache_valid_d = 1'b0;
    end else if ((state_q == REQ) && key_ack) begin
      cache_valid_d = 1'b1;
      cache_id_d    = key_id_q;
      cache_key_d   = key;
    end else begin
      cache_valid_d = cache_valid_q;
    end
  end
`else
  logic unused_flush_s;

  assign unused_flush_s = cache_flush;
  assign cache_hit_s    = 1'b0;
  assign cache_key_s    = {KEY_WIDTH{1'b0}};
`endif

  assign timeout_s = (wait_q == WAIT_LAST);

  // State and datapath registers.
  always_ff @(posedge clk156) begin
    if (areset_clk156) begin
      state_q        <= IDLE;
      wait_q         <= {WAIT_W{1'b0}};
      key_id_q       <= {ID_WIDTH{1'b0}};
      result_ok_q    <= 1'b0;
      result_key_q   <= {KEY_WIDTH{1'b0}};
      timeout_cnt_q  <= {TIMEOUT_CNT_WIDTH{1'b0}};
      key_req_q      <= 1'b0;
      lookup_ready_q <= 1'b1;
      result_valid_q <= 1'b0;
`ifdef KEY_FETCH_CLIENT_CACHE_EN
      cache_valid_q  <= 1'b0;
      cache_id_q     <= {ID_WIDTH{1'b0}};
      cache_key_q    <= {KEY_WIDTH{1'b0}};
`endif
    end else begin
      state_q        <= state_d;
      wait_q         <= wait_d;
      key_id_q       <= key_id_d;
      result_ok_q    <= result_ok_d;
      result_key_q   <= result_key_d;
      timeout_cnt_q  <= timeout_cnt_d;
      key_req_q      <= key_req_d;
      lookup_ready_q <= lookup_ready_d;
      result_valid_q <= result_valid_d;
`ifdef KEY_FETCH_CLIENT_CACHE_EN
      cache_valid_q  <= cache_valid_d;
      cache_id_q     <= cache_id_d;
      cache_key_q    <= cache_key_d;
`endif
    end
  end

  // Next-state logic; an ack in the timeout cycle still completes the fetch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (lookup_valid) begin
          state_d = cache_hit_s ? RESP : REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (key_ack || timeout_s) begin
          state_d = RESP;
        end else begin
          state_d = REQ;
        end
      end
      RESP: begin
        if (result_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; handshake flags are registered from state_d.
  always_comb begin
    wait_d        = wait_q;
    key_id_d      = key_id_q;
    result_ok_d   = result_ok_q;
    result_key_d  = result_key_q;
    timeout_cnt_d = timeout_cnt_q;
    case (state_q)
      IDLE: begin
        if (lookup_valid) begin
          key_id_d = lookup_id;
          wait_d   = {WAIT_W{1'b0}};
          if (cache_hit_s) begin
            result_ok_d  = 1'b1;
            result_key_d = cache_key_s;
          end else begin
            result_ok_d  = result_ok_q;
          end
        end else begin
          key_id_d = key_id_q;
        end
      end
      REQ: begin
        wait_d = wait_q + WAIT_W'(1);
        if (key_ack) begin
          result_ok_d  = 1'b1;
          result_key_d = key;
        end else if (timeout_s) begin
          result_ok_d  = 1'b0;
          result_key_d = {KEY_WIDTH{1'b0}};
          if (timeout_cnt_q != TCNT_MAX) begin
            timeout_cnt_d = timeout_cnt_q + TIMEOUT_CNT_WIDTH'(1);
          end else begin
            timeout_cnt_d = timeout_cnt_q;
          end
        end else begin
          result_ok_d = result_ok_q;
        end
      end
      RESP: begin
        wait_d = wait_q;
      end
      default: begin
        wait_d = {WAIT_W{1'b0}};
      end
    endcase
    key_req_d      = (state_d == REQ);
    lookup_ready_d = (state_d == IDLE);
    result_valid_d = (state_d == RESP);
  end

  assign lookup_ready = lookup_ready_q;
  assign key_req      = key_req_q;
  assign key_id       = key_id_q;
  assign result_valid = result_valid_q;
  assign result_ok    = result_ok_q;
  assign result_key   = result_key_q;
  assign timeout_cnt  = 16'(timeout_cnt_q);

endmodule

// File: tb/tb_key_fetch_client.sv
// tb_key_fetch_client: directed self-checking bench for key_fetch_client.
// Cache checks follow KEY_FETCH_CLIENT_CACHE_EN; saturation uses a narrow-counter instance.
module tb_key_fetch_client;
  localparam int unsigned KW = 256;
  localparam int unsigned IW = 32;
  localparam logic [KW-1:0] KEY_A5 = {32{8'hA5}};
  localparam logic [KW-1:0] KEY_B1 = {32{8'hB1}};
  localparam logic [KW-1:0] KEY_C3 = {32{8'hC3}};
  localparam logic [KW-1:0] KEY_5A = {32{8'h5A}};
  localparam logic [KW-1:0] KEY_77 = {32{8'h77}};
  localparam logic [KW-1:0] KEY_FF = {32{8'hFF}};

  logic clk156 = 1'b0;
  always #5 clk156 = ~clk156;

  logic          rst, lookup_valid, result_ready, key_ack, cache_flush;
  logic [IW-1:0] lookup_id;
  logic [KW-1:0] key;
  logic          lookup_ready, result_valid, result_ok, key_req;
  logic [IW-1:0] key_id;
  logic [KW-1:0] result_key;
  logic [15:0]   timeout_cnt;

  logic          s_rst, s_lv, s_rr, s_ack, s_flush;
  logic [IW-1:0] s_id;
  logic [KW-1:0] s_key;
  logic          s_lr, s_rv, s_ok, s_req;
  logic [IW-1:0] s_kid;
  logic [KW-1:0] s_rkey;
  logic [15:0]   s_tcnt;

  int nvec = 0;
  int nmis = 0;

  key_fetch_client #(.TIMEOUT_CYCLES(8), .KEY_WIDTH(KW), .ID_WIDTH(IW)) dut (
    .clk156(clk156), .areset_clk156(rst),
    .lookup_valid(lookup_valid), .lookup_ready(lookup_ready), .lookup_id(lookup_id),
    .result_valid(result_valid), .result_ready(result_ready), .result_ok(result_ok),
    .result_key(result_key), .key_req(key_req), .key_id(key_id), .key_ack(key_ack),
    .key(key), .cache_flush(cache_flush), .timeout_cnt(timeout_cnt)
  );

  key_fetch_client #(.TIMEOUT_CYCLES(2), .KEY_WIDTH(KW), .ID_WIDTH(IW),
                     .TIMEOUT_CNT_WIDTH(4)) dut_sat (
    .clk156(clk156), .areset_clk156(s_rst),
    .lookup_valid(s_lv), .lookup_ready(s_lr), .lookup_id(s_id),
    .result_valid(s_rv), .result_ready(s_rr), .result_ok(s_ok),
    .result_key(s_rkey), .key_req(s_req), .key_id(s_kid), .key_ack(s_ack),
    .key(s_key), .cache_flush(s_flush), .timeout_cnt(s_tcnt)
  );

  task automatic tick();
    @(posedge clk156);
    #1;
  endtask

  // Plain miss transaction: accept, ack in the first REQ cycle, consume the result.
  task automatic do_fetch(input logic [IW-1:0] id, input logic [KW-1:0] k);
    lookup_id = id; lookup_valid = 1'b1; tick(); lookup_valid = 1'b0;
    key_ack = 1'b1; key = k; tick(); key_ack = 1'b0;
    result_ready = 1'b1; tick(); result_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    nvec++; if ({lookup_ready, key_req, result_valid, result_ok} !== 4'b1000) begin
      nmis++; $display("FAIL reset_flags: got %b expected 1000", {lookup_ready, key_req, result_valid, result_ok}); end
    nvec++; if (key_id !== '0) begin nmis++; $display("FAIL reset_key_id: got %h expected 0", key_id); end
    nvec++; if (result_key !== '0) begin nmis++; $display("FAIL reset_result_key: got %h expected 0", result_key); end
    nvec++; if (timeout_cnt !== 16'h0) begin nmis++; $display("FAIL reset_timeout_cnt: got %h expected 0", timeout_cnt); end
  endtask

  task automatic test_basic_fetch();
    logic [2:0] seen;
    lookup_id = 32'h0000_0005; lookup_valid = 1'b1; tick(); lookup_valid = 1'b0;
    seen[0] = key_req;
    nvec++; if (key_id !== 32'h5) begin nmis++; $display("FAIL t1_key_id: got %h expected 5", key_id); end
    nvec++; if (lookup_ready !== 1'b0) begin nmis++; $display("FAIL t1_busy: got %b expected 0", lookup_ready); end
    tick(); seen[1] = key_req;
    tick(); seen[2] = key_req;
    key_ack = 1'b1; key = KEY_A5; tick(); key_ack = 1'b0; key = '0;
    nvec++; if ({seen, key_req} !== 4'b1110) begin nmis++; $display("FAIL t1_req_pulse: got %b expected 1110", {seen, key_req}); end
    nvec++; if ({result_valid, result_ok} !== 2'b11) begin nmis++; $display("FAIL t1_valid_ok: got %b expected 11", {result_valid, result_ok}); end
    nvec++; if (result_key !== KEY_A5) begin nmis++; $display("FAIL t1_key: got %h expected %h", result_key, KEY_A5); end
    nvec++; if (timeout_cnt !== 16'h0) begin nmis++; $display("FAIL t1_tcnt: got %h expected 0", timeout_cnt); end
    result_ready = 1'b1; tick(); result_ready = 1'b0;
    nvec++; if ({result_valid, lookup_ready, key_req} !== 3'b010) begin
      nmis++; $display("FAIL t1_release: got %b expected 010", {result_valid, lookup_ready, key_req}); end
  endtask

  task automatic test_zero_wait();
    lookup_id = 32'd9; lookup_valid = 1'b1; tick(); lookup_valid = 1'b0;
    nvec++; if ({key_req, result_valid} !== 2'b10) begin nmis++; $display("FAIL zw_req: got %b expected 10", {key_req, result_valid}); end
    key_ack = 1'b1; key = KEY_B1; result_ready = 1'b1; tick(); key_ack = 1'b0;
    nvec++; if ({result_valid, result_ok, key_req} !== 3'b110) begin
      nmis++; $display("FAIL zw_result: got %b expected 110", {result_valid, result_ok, key_req}); end
    nvec++; if (result_key !== KEY_B1) begin nmis++; $display("FAIL zw_key: got %h expected %h", result_key, KEY_B1); end
    tick(); result_ready = 1'b0;
    nvec++; if ({result_valid, lookup_ready} !== 2'b01) begin nmis++; $display("FAIL zw_single_cycle: got %b expected 01", {result_valid, lookup_ready}); end
  endtask

  task automatic test_timeout();
    int cnt;
    cnt = 0;
    lookup_id = 32'd3; lookup_valid = 1'b1; tick(); lookup_valid = 1'b0;
    while (key_req === 1'b1 && cnt < 20) begin cnt++; tick(); end
    nvec++; if (cnt != 8) begin nmis++; $display("FAIL t2_req_cycles: got %0d expected 8", cnt); end
    nvec++; if ({result_valid, result_ok} !== 2'b10) begin nmis++; $display("FAIL t2_valid_ok: got %b expected 10", {result_valid, result_ok}); end
    nvec++; if (result_key !== '0) begin nmis++; $display("FAIL t2_key: got %h expected 0", result_key); end
    nvec++; if (timeout_cnt !== 16'h1) begin nmis++; $display("FAIL t2_tcnt: got %h expected 1", timeout_cnt); end
    tick(); tick();
    key_ack = 1'b1; key = KEY_FF; tick(); key_ack = 1'b0; key = '0;
    nvec++; if ({result_valid, result_ok, key_req} !== 3'b100 || result_key !== '0 || timeout_cnt !== 16'h1) begin
      nmis++; $display("FAIL t2_late_ack_resp: got v/ok/req=%b key=%h tcnt=%h expected 100 0 1", {result_valid, result_ok, key_req}, result_key, timeout_cnt); end
    result_ready = 1'b1; tick(); result_ready = 1'b0;
    key_ack = 1'b1; key = KEY_FF; tick(); key_ack = 1'b0; key = '0;
    nvec++; if ({lookup_ready, key_req, result_valid} !== 3'b100 || result_key !== '0) begin
      nmis++; $display("FAIL t2_late_ack_idle: got flags=%b key=%h expected 100 0", {lookup_ready, key_req, result_valid}, result_key); end
  endtask

  task automatic test_collide();
    lookup_id = 32'd4; lookup_valid = 1'b1; tick(); lookup_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    nvec++; if (key_req !== 1'b1) begin nmis++; $display("FAIL t3_still_req: got %b expected 1", key_req); end
    key_ack = 1'b1; key = KEY_C3; tick(); key_ack = 1'b0; key = '0;
    nvec++; if ({result_valid, result_ok} !== 2'b11) begin nmis++; $display("FAIL t3_ok: got %b expected 11", {result_valid, result_ok}); end
    nvec++; if (result_key !== KEY_C3) begin nmis++; $display("FAIL t3_key: got %h expected %h", result_key, KEY_C3); end
    nvec++; if (timeout_cnt !== 16'h1) begin nmis++; $display("FAIL t3_tcnt: got %h expected 1", timeout_cnt); end
    result_ready = 1'b1; tick(); result_ready = 1'b0;
  endtask

  task automatic test_backpressure_reset();
    lookup_id = 32'd6; lookup_valid = 1'b1; tick(); lookup_valid = 1'b0;
    tick();
    key_ack = 1'b1; key = KEY_5A; tick(); key_ack = 1'b0; key = '0;
    for (int i = 0; i < 10; i++) begin
      nvec++; if ({result_valid, result_ok, lookup_ready} !== 3'b110 || result_key !== KEY_5A) begin
        nmis++; $display("FAIL t4_hold_%0d: got v/ok/rdy=%b key=%h expected 110 %h", i, {result_valid, result_ok, lookup_ready}, result_key, KEY_5A); end
      tick();
    end
    result_ready = 1'b1; tick(); result_ready = 1'b0;
    lookup_id = 32'd8; lookup_valid = 1'b1; tick(); lookup_valid = 1'b0;
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    nvec++; if ({lookup_ready, key_req, result_valid, result_ok} !== 4'b1000) begin
      nmis++; $display("FAIL t4_rst_flags: got %b expected 1000", {lookup_ready, key_req, result_valid, result_ok}); end
    nvec++; if (key_id !== '0 || result_key !== '0 || timeout_cnt !== 16'h0) begin
      nmis++; $display("FAIL t4_rst_data: got id=%h key=%h tcnt=%h expected all 0", key_id, result_key, timeout_cnt); end
  endtask

  task automatic test_cache();
    do_fetch(32'd7, KEY_77);
    lookup_id = 32'd7; lookup_valid = 1'b1; tick(); lookup_valid = 1'b0;
`ifdef KEY_FETCH_CLIENT_CACHE_EN
    nvec++; if ({key_req, result_valid, result_ok} !== 3'b011) begin
      nmis++; $display("FAIL t5_hit: got req/v/ok=%b expected 011", {key_req, result_valid, result_ok}); end
    nvec++; if (result_key !== KEY_77) begin nmis++; $display("FAIL t5_hit_key: got %h expected %h", result_key, KEY_77); end
    result_ready = 1'b1; tick(); result_ready = 1'b0;
`else
    nvec++; if (key_req !== 1'b1) begin nmis++; $display("FAIL t5_nocache_req: got %b expected 1", key_req); end
    key_ack = 1'b1; key = KEY_77; tick(); key_ack = 1'b0;
    result_ready = 1'b1; tick(); result_ready = 1'b0;
`endif
    cache_flush = 1'b1; tick(); cache_flush = 1'b0;
    lookup_id = 32'd7; lookup_valid = 1'b1; tick(); lookup_valid = 1'b0;
    nvec++; if ({key_req, result_valid} !== 2'b10) begin nmis++; $display("FAIL t5_after_flush: got %b expected 10", {key_req, result_valid}); end
    key_ack = 1'b1; key = KEY_77; tick(); key_ack = 1'b0;
    result_ready = 1'b1; tick(); result_ready = 1'b0;
`ifdef KEY_FETCH_CLIENT_CACHE_EN
    lookup_id = 32'd7; lookup_valid = 1'b1; cache_flush = 1'b1; tick(); lookup_valid = 1'b0; cache_flush = 1'b0;
    nvec++; if ({key_req, result_valid} !== 2'b10) begin nmis++; $display("FAIL t5_flush_at_accept: got %b expected 10", {key_req, result_valid}); end
    key_ack = 1'b1; key = KEY_77; tick(); key_ack = 1'b0;
    result_ready = 1'b1; tick(); result_ready = 1'b0;
`endif
  endtask

  // Narrow instance: 4 cycles per timeout, 17 timeouts overflow a 4-bit counter.
  task automatic test_saturation();
    s_rst = 1'b0;
    for (int i = 0; i < 56; i++) tick();
    nvec++; if (s_tcnt !== 16'd14) begin nmis++; $display("FAIL t6_count: got %h expected 000e", s_tcnt); end
    for (int i = 0; i < 12; i++) tick();
    nvec++; if (s_tcnt !== 16'h000F) begin nmis++; $display("FAIL t6_saturate: got %h expected 000f", s_tcnt); end
  endtask

  initial begin
    rst = 1'b1; lookup_valid = 1'b0; lookup_id = '0; result_ready = 1'b0;
    key_ack = 1'b0; key = '0; cache_flush = 1'b0;
    s_rst = 1'b1; s_lv = 1'b1; s_id = '0; s_rr = 1'b1; s_ack = 1'b0; s_key = '0; s_flush = 1'b0;
    test_reset();
    test_basic_fetch();
    test_zero_wait();
    test_timeout();
    test_collide();
    test_backpressure_reset();
    test_cache();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 ns, required finish earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
